// File: rtl/helios_msg_pkg.sv
// Message codes, sizing helpers and sequencer state type shared by the
// Helios host-side shot sequencer.
package helios_msg_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [2:0] {
    S_SEND_START,
    S_IDLE,
    S_SEND_HEADER,
    S_SEND_DATA,
    S_WAIT_RESULT,
    S_RECV_RESULT,
    S_REPORT
  } seq_state_t;

  // Bytes needed to carry one measurement round of X*Z syndrome bits.
  function automatic int calc_bpr(input int gx, input int gz);
    return (gx * gz + 7) / 8;
  endfunction

  function automatic int calc_aligned_pu(input int gx, input int gz);
    return calc_bpr(gx, gz) * 8;
  endfunction

endpackage

// File: rtl/result_timeout_timer.sv
// Clear/enable cycle counter that flags when the result wait budget is used up.
module result_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  assign expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/decode_shot_sequencer.sv
// Frames syndrome shots onto the Helios decoder byte stream and gathers the
// fixed-length result message, with a timeout guard on the reply.
module decode_shot_sequencer
  import helios_msg_pkg::*;
#(
  parameter int GRID_WIDTH_X   = 4,
  parameter int GRID_WIDTH_Z   = 1,
  parameter int GRID_WIDTH_U   = 3,
  parameter int RESULT_BYTES   = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [calc_aligned_pu(GRID_WIDTH_X, GRID_WIDTH_Z)*GRID_WIDTH_U-1:0] shot_data,
  input  logic        shot_valid,
  output logic        shot_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        result_valid,
  output logic [7:0]  result_iterations,
  output logic [15:0] result_cycles,
  output logic        result_timeout,
  output logic [31:0] shots_done,
  output logic [15:0] rx_dropped
);

  localparam int BPR = calc_bpr(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int N   = BPR * GRID_WIDTH_U;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = $clog2(RESULT_BYTES);

  seq_state_t      r_state;
  logic [8*N-1:0]  r_shot;
  logic [IW-1:0]   r_tx_idx;
  logic [RW-1:0]   r_rx_idx;
  logic [7:0]      r_rx_iter;
  logic [15:0]     r_rx_cyc;

  logic [N-1:0][7:0] w_shot_bytes;
  logic [7:0]  w_tx_byte;
  logic        w_in_wait;
  logic        w_tx_fire;
  logic        w_rx_fire;
  logic        w_shot_fire;
  logic        w_rx_take;
  logic        w_rx_last;
  logic        w_expired;
  logic [7:0]  w_iter_nxt;
  logic [15:0] w_cyc_nxt;

  assign w_shot_bytes = r_shot;
  assign w_in_wait    = (r_state == S_WAIT_RESULT) || (r_state == S_RECV_RESULT);

  // Handshake outputs are held low for as long as reset is asserted.
  assign tx_valid   = !reset && ((r_state == S_SEND_START) || (r_state == S_SEND_HEADER) ||
                                 (r_state == S_SEND_DATA));
  assign shot_ready = !reset && (r_state == S_IDLE);
  assign rx_ready   = !reset && ((r_state == S_IDLE) || w_in_wait);

  assign w_tx_fire   = tx_valid && tx_ready;
  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_shot_fire = shot_valid && shot_ready;
  assign w_rx_take   = w_rx_fire && w_in_wait;
  assign w_rx_last   = w_rx_take && (r_rx_idx == RW'(RESULT_BYTES - 1));

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      S_SEND_START:  w_tx_byte = START_DECODING_MSG;
      S_SEND_HEADER: w_tx_byte = MEASUREMENT_DATA_HEADER;
      S_SEND_DATA:   w_tx_byte = w_shot_bytes[r_tx_idx];
      default:       w_tx_byte = 8'h00;
    endcase
    tx_data = tx_valid ? w_tx_byte : 8'h00;
  end

  // Result fields as they will be after this cycle's rx byte, so a final byte
  // landing on the report transition is not lost.
  always_comb begin
    w_iter_nxt = r_rx_iter;
    w_cyc_nxt  = r_rx_cyc;
    if (w_rx_take) begin
      if (r_rx_idx == RW'(0))      w_iter_nxt      = rx_data;
      else if (r_rx_idx == RW'(1)) w_cyc_nxt[15:8] = rx_data;
      else if (r_rx_idx == RW'(2)) w_cyc_nxt[7:0]  = rx_data;
    end
  end

  result_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!w_in_wait),
    .en     (w_in_wait),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_SEND_START;
      r_shot            <= '0;
      r_tx_idx          <= '0;
      r_rx_idx          <= '0;
      r_rx_iter         <= 8'h00;
      r_rx_cyc          <= 16'h0000;
      result_valid      <= 1'b0;
      result_iterations <= 8'h00;
      result_cycles     <= 16'h0000;
      result_timeout    <= 1'b0;
      shots_done        <= 32'd0;
      rx_dropped        <= 16'd0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        S_SEND_START: if (w_tx_fire) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_rx_fire && (rx_dropped != 16'hFFFF)) rx_dropped <= rx_dropped + 16'd1;
          if (w_shot_fire) begin
            r_shot  <= shot_data;
            r_state <= S_SEND_HEADER;
          end
        end
        S_SEND_HEADER: if (w_tx_fire) begin
          r_tx_idx <= '0;
          r_state  <= S_SEND_DATA;
        end
        S_SEND_DATA: if (w_tx_fire) begin
          if (r_tx_idx == IW'(N - 1)) begin
            r_rx_idx  <= '0;
            r_rx_iter <= 8'h00;
            r_rx_cyc  <= 16'h0000;
            r_state   <= S_WAIT_RESULT;
          end else begin
            r_tx_idx <= r_tx_idx + IW'(1);
          end
        end
        S_WAIT_RESULT, S_RECV_RESULT: begin
          if (w_rx_take) begin
            r_rx_idx  <= r_rx_idx + RW'(1);
            r_rx_iter <= w_iter_nxt;
            r_rx_cyc  <= w_cyc_nxt;
            r_state   <= S_RECV_RESULT;
          end
          if (w_rx_last || w_expired) begin
            result_iterations <= w_iter_nxt;
            result_cycles     <= w_cyc_nxt;
            result_timeout    <= !w_rx_last;
            result_valid      <= 1'b1;
            shots_done        <= shots_done + 32'd1;
            r_state           <= S_REPORT;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_SEND_START;
      endcase
    end
  end

endmodule

// File: doc/decode_shot_sequencer.md
# decode_shot_sequencer

Host-side sequencer that drives the byte-stream interface of `Helios_single_FPGA`. After reset it issues the start-decoding message once. It then frames each accepted syndrome shot as a measurement header followed by the padded measurement bytes, and collects the decoder's fixed-length result message into parallel result registers with timeout protection. It sits between the syndrome source and the decoder's input/output FIFOs, and replaces bench-style loading logic in hardware builds.

## Interface
Parameters:
- `GRID_WIDTH_X`, default 4: decoder grid X width.
- `GRID_WIDTH_Z`, default 1: decoder grid Z width.
- `GRID_WIDTH_U`, default 3: number of measurement rounds.
- `RESULT_BYTES`, default 3: result message length in bytes. Must be at least 3.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for a complete result.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `shot_data`, in, `ALIGNED_PU_PER_ROUND*GRID_WIDTH_U`: padded measurement bits.
- `shot_valid`, in, 1; `shot_ready`, out, 1: shot handshake.
- `tx_data`, out, 8; `tx_valid`, out, 1; `tx_ready`, in, 1: stream to the decoder input FIFO.
- `rx_data`, in, 8; `rx_valid`, in, 1; `rx_ready`, out, 1: stream from the decoder output FIFO.
- `result_valid`, out, 1: one-cycle result pulse.
- `result_iterations`, out, 8.
- `result_cycles`, out, 16.
- `result_timeout`, out, 1.
- `shots_done`, out, 32: completed shots, including timed-out shots.
- `rx_dropped`, out, 16: count of stray rx bytes accepted in IDLE. Saturates.

## Operation
- Derived values: `BPR = (GRID_WIDTH_X*GRID_WIDTH_Z+7)>>3` and `N = BPR*GRID_WIDTH_U`.
- States and transitions:
  - SEND_START (entered on reset): offer `START_DECODING_MSG`. Go to IDLE on accept.
  - IDLE: `shot_ready`=1 and `rx_ready`=1. Every rx byte accepted here is discarded and increments `rx_dropped`. When a shot is accepted, latch it into `shot_reg` and go to SEND_HEADER.
  - SEND_HEADER: offer `MEASUREMENT_DATA_HEADER`. On accept, clear the byte index and go to SEND_DATA.
  - SEND_DATA: `tx_data = shot_reg[8*idx +: 8]`, least-significant byte first. The index advances on accept. After byte `N-1` is accepted, clear the byte count and timer and go to WAIT_RESULT.
  - WAIT_RESULT / RECV_RESULT: `rx_ready`=1.
    - The first accepted byte moves the FSM to RECV_RESULT.
    - Byte 0 → `result_iterations`.
    - Byte 1 → `result_cycles[15:8]`.
    - Byte 2 → `result_cycles[7:0]`.
    - Bytes 3 through `RESULT_BYTES-1` are consumed and ignored.
    - After the last byte is accepted, go to REPORT with `result_timeout`=0.
  - Timeout: the timer counts every cycle spent in WAIT_RESULT or RECV_RESULT. When it reaches `TIMEOUT_CYCLES-1` without completion, go to REPORT with `result_timeout`=1. Result fields not yet received read 0.
  - REPORT: `result_valid`=1 for one cycle and `shots_done` increments. Next state is IDLE.
- Simultaneous events:
  - If the final rx byte and the timeout occur in the same cycle, the byte wins and `result_timeout`=0.
  - `shots_done` wraps at 2^32.
- `tx_valid`, once asserted, holds `tx_data` stable until `tx_ready` is sampled high.
- Result registers keep their values until the next REPORT.

## Timing
- Reset values:
  - `tx_valid`=0, `shot_ready`=0, `rx_ready`=0, `result_valid`=0, `result_timeout`=0.
  - `result_iterations`=0, `result_cycles`=0, `shots_done`=0, `rx_dropped`=0.
  - `tx_data`=0 while `tx_valid`=0.
- The first cycle after reset deasserts is in SEND_START with `tx_valid`=1.
- A shot accepted in cycle T has its header offered in cycle T+1. With `tx_ready` held high, the last data byte is accepted at T+1+N.
- The final result byte accepted in cycle R gives `result_valid` in cycle R+1 and `shot_ready` in cycle R+2.
- Reset mid-operation aborts immediately and the START message is resent. Partially sent shots are not resumed.

## Structure
- Package `helios_msg_pkg` holds:
  - `START_DECODING_MSG` = 8'h01.
  - `MEASUREMENT_DATA_HEADER` = 8'h02.
  - The `BPR` and aligned-width helper functions.
  - The state enum `seq_state_t`.
- Sub-module `result_timeout_timer`: clear/enable counter with a `$clog2(TIMEOUT_CYCLES)`-bit width and an `expired` output.

## Test plan
Defaults apply (N=3).
- Reset release with `tx_ready`=1 → `tx_data` 01 in the first cycle, then `shot_ready`=1.
- `shot_data`=24'h000001 with `tx_ready`=1 → tx sequence 02, 01, 00, 00 on consecutive cycles. Then rx 05, 01, 2C → `result_valid` pulse with `result_iterations`=5, `result_cycles`=300, `result_timeout`=0, `shots_done`=1.
- Same shot with `tx_ready` toggled every other cycle → identical byte order, and `tx_data` stable while stalled.
- `TIMEOUT_CYCLES`=16 with rx delivering only 07 → `result_valid` 16 cycles after entering WAIT_RESULT, with `result_timeout`=1, `result_iterations`=7, `result_cycles`=0.
- Two stray rx bytes while in IDLE → `rx_dropped`=2 and no `result_valid`.
- Reset asserted after the second data byte → the next tx byte is 01 (START) and `shots_done` reads 0.
